button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Parametrised input conditioner for N player buttons between the pad inputs and the game core.
- Per channel: optional polarity inversion, multi-stage synchroniser, counter debouncer, edge detection, and a per-channel auto-repeat engine (delayed auto-shift) for held buttons.
- Replaces direct pin-to-core wiring of active-low buttons with clean, one-cycle action pulses.

Parameters:
- N_BTN, 4, number of button channels.
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- DEBOUNCE_CYCLES, 250000, consecutive cycles of disagreement required to accept a new level (>=1).
- REPEAT_DELAY, 5000000, cycles from press pulse to first repeat pulse (>=2).
- REPEAT_RATE, 1250000, cycles between subsequent repeat pulses (>=1).
- ACTIVE_LOW, {N_BTN{1'b1}}, per-channel bitmask; 1 = raw pin low means pressed.
- REPEAT_MASK, {N_BTN{1'b1}}, per-channel bitmask; 1 = auto-repeat enabled.

Ports:
- clock  in  1  system clock (pixel clock domain)
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 = pulses and repeat active; 0 = press/release/action forced 0, repeat FSMs held in IDLE, level keeps tracking
- raw_in  in  N_BTN  asynchronous raw button pins
- level  out  N_BTN  debounced pressed state (1 = pressed)
- press  out  N_BTN  one-cycle pulse on debounced press
- release  out  N_BTN  one-cycle pulse on debounced release
- action  out  N_BTN  press pulse OR auto-repeat pulse

Behaviour:
- Clock and reset: one clock `clock`; reset is synchronous and active-high.
- Reset values:
  - All synchroniser flops reset to logical inactive (post-inversion 0).
  - level, press, release, action = 0; all counters 0; every repeat FSM in IDLE.
- Polarity: logical input x[i] = raw_in[i] XOR ACTIVE_LOW[i], applied before the first sync flop.
- Debouncer, per channel:
  - Registered `stable` drives level; counter `dcnt` of width $clog2(DEBOUNCE_CYCLES+1).
  - sync == stable: dcnt <= 0.
  - sync != stable and dcnt == DEBOUNCE_CYCLES-1: stable <= sync, dcnt <= 0.
  - Otherwise: dcnt <= dcnt+1.
- Latency: a steady raw change first sampled on edge 1 changes level on edge SYNC_STAGES+DEBOUNCE_CYCLES. Any disagreement shorter than DEBOUNCE_CYCLES is discarded with no output effect.
- Edges:
  - press[i] = 1 for exactly the first cycle level[i] is 1.
  - release[i] = 1 for exactly the first cycle level[i] is 0 after being 1.
  - Both are gated by enable.
- Repeat FSM, per channel with REPEAT_MASK[i]=1; states IDLE, DELAY, RATE; shared counter rcnt sized for max(REPEAT_DELAY, REPEAT_RATE).
  - IDLE: on press cycle -> DELAY, rcnt <= 0.
  - DELAY: rcnt increments; when rcnt == REPEAT_DELAY-1 -> repeat pulse this cycle, go to RATE, rcnt <= 0.
  - RATE: rcnt increments; when rcnt == REPEAT_RATE-1 -> repeat pulse, rcnt <= 0, stay in RATE.
  - level==0 in any state: -> IDLE next edge, no pulse in that cycle.
  - enable==0: -> IDLE, rcnt <= 0. Re-enabling while held does not restart repeat; the next press does.
- Repeat timing: first repeat lands REPEAT_DELAY cycles after the press cycle, then every REPEAT_RATE cycles.
- action[i] = press[i] | repeat_pulse[i]. With REPEAT_MASK[i]=0, action = press only.
- Simultaneous events: channels are fully independent; any combination of channels may pulse in the same cycle.
- Release during the cycle a repeat would fire: release wins, no repeat pulse.
- Reset mid-operation: on the next edge, all state returns to reset values. A button still held after reset is re-detected as a fresh press with full sync+debounce latency.
- Counters never wrap: each is cleared at its terminal count.

Test Plan:
Common parameters: N_BTN=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, ACTIVE_LOW=4'hF, REPEAT_MASK=4'b0011, enable=1. Cycle n = cycle following edge n.
1. Clean hold: raw_in[0] 1->0 sampled at edge 1, held 40 cycles -> level[0] rises at edge 6; press[0] in cycle 6 only; action[0] in cycles 6, 16, 19, 22, 25, ...; other channels stay 0.
2. Bounce and glitch:
   - raw_in[1] low for 3 cycles, then high -> level, press and action never assert.
   - raw_in[1] toggles every 2 cycles for 12 cycles, then held low -> exactly one press, 6 edges after the last toggle.
3. Release: from case 1, raw_in[0] -> 1 -> level falls 6 edges later; release[0] one cycle; no further action.
   - Re-press -> next repeat lands 10 cycles after the new press pulse, not on the old cadence.
4. Non-repeat channel and enable:
   - raw_in[2] held 40 cycles -> exactly one action[2] pulse.
   - Hold ch0 with enable=0 -> level[0] rises; press, action and release all 0.
5. Reset mid-repeat: ch1 held in RATE, reset asserted 1 cycle -> all outputs 0 at next edge.
   - Release reset with ch1 still held -> press[1] 6 edges after reset deasserts; first repeat 10 cycles later.
6. Multi-channel: raw_in[0] and raw_in[1] pressed on the same edge -> identical, simultaneous press and action pulse trains on both channels.

Source files
------------

// File: rtl/button_conditioner.sv
// Conditions N active-low player buttons into debounced levels, one-cycle press/release
// pulses and an action pulse train with delayed auto-repeat for held buttons.
module button_conditioner #(
   parameter int unsigned      N_BTN           = 4,
   parameter int unsigned      SYNC_STAGES     = 2,
   parameter int unsigned      DEBOUNCE_CYCLES = 250000,
   parameter int unsigned      REPEAT_DELAY    = 5000000,
   parameter int unsigned      REPEAT_RATE     = 1250000,
   parameter logic [N_BTN-1:0] ACTIVE_LOW      = {N_BTN{1'b1}},
   parameter logic [N_BTN-1:0] REPEAT_MASK     = {N_BTN{1'b1}}
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic [N_BTN-1:0] raw_in,
   output logic [N_BTN-1:0] level,
   output logic [N_BTN-1:0] press,
   output logic [N_BTN-1:0] release_pulse,  // "release" is a reserved word
   output logic [N_BTN-1:0] action
);

   localparam int unsigned DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned RMAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned RCNT_W = (RMAX > 1) ? $clog2(RMAX) : 1;

   localparam logic [DCNT_W-1:0] DEB_TERM   = DCNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RCNT_W-1:0] DELAY_TERM = RCNT_W'(REPEAT_DELAY - 1);
   localparam logic [RCNT_W-1:0] RATE_TERM  = RCNT_W'(REPEAT_RATE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DELAY = 2'd1,
      RATE  = 2'd2
   } rpt_state_t;

   logic [N_BTN-1:0]  sync_q [SYNC_STAGES];
   logic [N_BTN-1:0]  sync_out;
   logic [DCNT_W-1:0] dcnt_q [N_BTN];
   logic [DCNT_W-1:0] dcnt_d [N_BTN];
   rpt_state_t        state_q [N_BTN];
   rpt_state_t        state_d [N_BTN];
   logic [RCNT_W-1:0] rcnt_q [N_BTN];
   logic [RCNT_W-1:0] rcnt_d [N_BTN];
   logic [N_BTN-1:0]  level_d;
   logic [N_BTN-1:0]  rise;
   logic [N_BTN-1:0]  fall;
   logic [N_BTN-1:0]  rpt_fire;

   assign sync_out = sync_q[SYNC_STAGES-1];

   // Next-cycle debouncer and repeat state; the repeat pulse is looked up on the
   // next-cycle values so it can be registered and still land in its own cycle.
   always_comb begin
      level_d  = level;
      rise     = '0;
      fall     = '0;
      rpt_fire = '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
         dcnt_d[i]  = '0;
         state_d[i] = state_q[i];
         rcnt_d[i]  = rcnt_q[i];

         if (sync_out[i] != level[i]) begin
            if (dcnt_q[i] == DEB_TERM) begin
               level_d[i] = sync_out[i];
               rise[i]    = sync_out[i];
               fall[i]    = ~sync_out[i];
            end else begin
               dcnt_d[i] = dcnt_q[i] + 1'b1;
            end
         end

         if (!REPEAT_MASK[i] || !enable || !level[i]) begin
            state_d[i] = IDLE;
            rcnt_d[i]  = '0;
         end else begin
            case (state_q[i])
               IDLE: begin
                  if (press[i]) begin
                     state_d[i] = DELAY;
                     rcnt_d[i]  = '0;
                  end
               end
               DELAY: begin
                  if (rcnt_q[i] == DELAY_TERM) begin
                     state_d[i] = RATE;
                     rcnt_d[i]  = '0;
                  end else begin
                     rcnt_d[i] = rcnt_q[i] + 1'b1;
                  end
               end
               RATE: begin
                  if (rcnt_q[i] == RATE_TERM) rcnt_d[i] = '0;
                  else                        rcnt_d[i] = rcnt_q[i] + 1'b1;
               end
               default: begin
                  state_d[i] = IDLE;
                  rcnt_d[i]  = '0;
               end
            endcase
         end

         // A release landing on a terminal count suppresses that repeat.
         rpt_fire[i] = REPEAT_MASK[i] && enable && level_d[i] &&
                       (((state_d[i] == DELAY) && (rcnt_d[i] == DELAY_TERM)) ||
                        ((state_d[i] == RATE)  && (rcnt_d[i] == RATE_TERM)));
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
         for (int unsigned i = 0; i < N_BTN; i++) begin
            dcnt_q[i]  <= '0;
            state_q[i] <= IDLE;
            rcnt_q[i]  <= '0;
         end
         level         <= '0;
         press         <= '0;
         release_pulse <= '0;
         action        <= '0;
      end else begin
         sync_q[0] <= raw_in ^ ACTIVE_LOW;
         for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
         for (int unsigned i = 0; i < N_BTN; i++) begin
            dcnt_q[i]  <= dcnt_d[i];
            state_q[i] <= state_d[i];
            rcnt_q[i]  <= rcnt_d[i];
         end
         level         <= level_d;
         press         <= rise & {N_BTN{enable}};
         release_pulse <= fall & {N_BTN{enable}};
         action        <= (rise & {N_BTN{enable}}) | rpt_fire;
      end
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised and directed bench for button_conditioner, checked against a history-based
// reference model that evaluates the debounce and repeat rules over recorded samples.
module tb_button_conditioner;

   localparam int          N     = 4;
   localparam int          SYNC  = 2;
   localparam int          DEB   = 4;
   localparam int          RD    = 10;
   localparam int          RR    = 3;
   localparam logic [3:0]  AL    = 4'hF;
   localparam logic [3:0]  MASK  = 4'b0011;
   localparam int          MAXE  = 4096;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b1;
   logic [3:0] raw_in = 4'hF;
   logic [3:0] level, press, release_pulse, action;

   int n_tests = 0;
   int n_fail  = 0;

   // Model history, indexed by edge number since the last reset edge.
   int         mn = 0;
   logic [3:0] xs     [MAXE];
   logic [3:0] lvl_h  [MAXE];
   logic       en_h   [MAXE];
   int         last_p [N];
   logic [3:0] e_level, e_press, e_rel, e_action;

   button_conditioner #(
      .N_BTN(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10),
      .REPEAT_RATE(3), .ACTIVE_LOW(4'hF), .REPEAT_MASK(4'b0011)
   ) dut (
      .clock(clk), .reset(reset), .enable(enable), .raw_in(raw_in),
      .level(level), .press(press), .release_pulse(release_pulse), .action(action)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      mn       = 0;
      xs[0]    = '0;
      lvl_h[0] = '0;
      en_h[0]  = 1'b0;
      for (int i = 0; i < N; i++) last_p[i] = 0;
      e_level = '0; e_press = '0; e_rel = '0; e_action = '0;
   endtask

   // Level flips once the synchronised input has disagreed with it for DEB whole
   // cycles; repeats fall at press+RD+k*RR while level and enable stay high.
   task automatic model_step();
      logic prev, cur, acc, s, ok;
      int   c, d;
      xs[mn]    = raw_in ^ AL;
      en_h[mn]  = enable;
      lvl_h[mn] = '0;
      for (int i = 0; i < N; i++) begin
         prev = lvl_h[mn-1][i];
         acc  = 1'b1;
         for (int j = 1; j <= DEB; j++) begin
            c = mn - j;
            if (c < 1) acc = 1'b0;
            else begin
               s = (c - SYNC + 1 >= 1) ? xs[c-SYNC+1][i] : 1'b0;
               if (s == prev || lvl_h[c][i] != prev) acc = 1'b0;
            end
         end
         cur          = acc ? ~prev : prev;
         lvl_h[mn][i] = cur;
         e_level[i]   = cur;
         e_press[i]   = cur & ~prev & enable;
         e_rel[i]     = ~cur & prev & enable;
         if (e_press[i]) last_p[i] = mn;
         ok = 1'b0;
         if (MASK[i] && last_p[i] > 0 && last_p[i] < mn) begin
            d  = mn - last_p[i];
            ok = (d >= RD) && ((d - RD) % RR == 0);
            for (int k = last_p[i]; k <= mn; k++) if (!lvl_h[k][i]) ok = 1'b0;
            for (int k = last_p[i] + 1; k <= mn; k++) if (!en_h[k]) ok = 1'b0;
         end
         e_action[i] = e_press[i] | ok;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset) model_reset();
      else begin
         if (mn + 1 >= MAXE) begin
            $display("FAIL model_overflow edge=%0d limit=%0d", mn, MAXE);
            $fatal(1);
         end
         mn++;
         model_step();
      end
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      enable = 1'b1;
      reset  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         raw_in = 4'($urandom_range(0, 15));
         tick();
         n_tests++;
         if ({level, press, release_pulse, action} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_state got l/p/r/a=%b/%b/%b/%b want all 0", level, press, release_pulse, action);
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_clean_hold();
      logic el, ep, ea;
      do_reset();
      raw_in = 4'b0001 ^ AL;
      for (int e = 1; e <= 40; e++) begin
         tick();
         el = (mn >= 6);
         ep = (mn == 6);
         ea = (mn == 6) || (mn >= 16 && (mn - 16) % 3 == 0);
         n_tests++;
         if ({level[0], press[0], action[0], release_pulse[0]} !== {el, ep, ea, 1'b0} ||
             {level[3:1], press[3:1], action[3:1], release_pulse[3:1]} !== 12'h0) begin
            n_fail++;
            $display("FAIL clean_hold edge=%0d got l/p/a/r=%b/%b/%b/%b want ch0 l=%b p=%b a=%b, others 0",
                     mn, level, press, action, release_pulse, el, ep, ea);
         end
         n_tests++;
         if ({level, press, release_pulse, action} !== {e_level, e_press, e_rel, e_action}) begin
            n_fail++;
            $display("FAIL clean_hold_model edge=%0d got %b/%b/%b/%b want %b/%b/%b/%b", mn,
                     level, press, release_pulse, action, e_level, e_press, e_rel, e_action);
         end
      end
   endtask

   task automatic test_release();
      int rel_cnt, rel_e, act_cnt, p_e, r_e;
      rel_cnt = 0; rel_e = 0; act_cnt = 0; p_e = 0; r_e = 0;
      do_reset();
      for (int e = 1; e <= 60; e++) begin
         if (e <= 20)      raw_in = 4'b0001 ^ AL;
         else if (e <= 40) raw_in = 4'b0000 ^ AL;
         else              raw_in = 4'b0001 ^ AL;
         tick();
         if (mn > 20 && mn <= 40) begin
            if (release_pulse[0]) begin rel_cnt++; rel_e = mn; end
            if (mn >= 26 && action[0]) act_cnt++;
         end
         if (mn > 40) begin
            if (press[0]) p_e = mn;
            if (action[0] && !press[0] && r_e == 0) r_e = mn;
         end
         n_tests++;
         if ({level, press, release_pulse, action} !== {e_level, e_press, e_rel, e_action}) begin
            n_fail++;
            $display("FAIL release_model edge=%0d got %b/%b/%b/%b want %b/%b/%b/%b", mn,
                     level, press, release_pulse, action, e_level, e_press, e_rel, e_action);
         end
      end
      n_tests++;
      if (rel_cnt !== 1 || rel_e !== 26) begin
         n_fail++;
         $display("FAIL release_pulse got count=%0d edge=%0d want count=1 edge=26", rel_cnt, rel_e);
      end
      n_tests++;
      if (act_cnt !== 0) begin
         n_fail++;
         $display("FAIL action_after_release got %0d pulses want 0", act_cnt);
      end
      n_tests++;
      if (p_e !== 46 || r_e !== 56) begin
         n_fail++;
         $display("FAIL repress_cadence got press=%0d first_repeat=%0d want 46 and 56", p_e, r_e);
      end
   endtask

   task automatic test_bounce();
      logic x1;
      int   glitch, pc, pe;
      glitch = 0; pc = 0; pe = 0;
      do_reset();
      for (int e = 1; e <= 45; e++) begin
         if (e <= 3)       x1 = 1'b1;
         else if (e <= 13) x1 = 1'b0;
         else if (e < 26)  x1 = (((e - 14) / 2) % 2 == 0);
         else              x1 = 1'b1;
         raw_in = {2'b00, x1, 1'b0} ^ AL;
         tick();
         if (mn <= 13 && (level[1] || press[1] || action[1])) glitch++;
         if (press[1]) begin pc++; pe = mn; end
         n_tests++;
         if ({level, press, release_pulse, action} !== {e_level, e_press, e_rel, e_action}) begin
            n_fail++;
            $display("FAIL bounce_model edge=%0d got %b/%b/%b/%b want %b/%b/%b/%b", mn,
                     level, press, release_pulse, action, e_level, e_press, e_rel, e_action);
         end
      end
      n_tests++;
      if (glitch !== 0) begin
         n_fail++;
         $display("FAIL short_glitch got %0d active cycles want 0", glitch);
      end
      n_tests++;
      if (pc !== 1 || pe !== 31) begin
         n_fail++;
         $display("FAIL bounce_press got count=%0d edge=%0d want count=1 edge=31", pc, pe);
      end
   endtask

   task automatic test_enable();
      int act2, ch0;
      act2 = 0; ch0 = 0;
      do_reset();
      for (int e = 1; e <= 122; e++) begin
         if (e <= 40)      begin raw_in = 4'b0100 ^ AL; enable = 1'b1; end
         else if (e <= 50) begin raw_in = 4'b0000 ^ AL; enable = 1'b1; end
         else if (e <= 70) begin raw_in = 4'b0001 ^ AL; enable = 1'b0; end
         else if (e <= 80) begin raw_in = 4'b0000 ^ AL; enable = 1'b0; end
         else if (e <= 92) begin raw_in = 4'b0001 ^ AL; enable = 1'b0; end
         else              begin raw_in = 4'b0001 ^ AL; enable = 1'b1; end
         tick();
         if (action[2]) act2++;
         if (mn > 50 && (press[0] || release_pulse[0] || action[0])) ch0++;
         if (mn == 70 || mn == 80) begin
            n_tests++;
            if (level[0] !== (mn == 70)) begin
               n_fail++;
               $display("FAIL disabled_level edge=%0d got %b want %b", mn, level[0], mn == 70);
            end
         end
         n_tests++;
         if ({level, press, release_pulse, action} !== {e_level, e_press, e_rel, e_action}) begin
            n_fail++;
            $display("FAIL enable_model edge=%0d got %b/%b/%b/%b want %b/%b/%b/%b", mn,
                     level, press, release_pulse, action, e_level, e_press, e_rel, e_action);
         end
      end
      enable = 1'b1;
      n_tests++;
      if (act2 !== 1) begin
         n_fail++;
         $display("FAIL no_repeat_channel got %0d action pulses want 1", act2);
      end
      n_tests++;
      if (ch0 !== 0) begin
         n_fail++;
         $display("FAIL disabled_pulses got %0d pulses on ch0 want 0", ch0);
      end
   endtask

   task automatic test_reset_mid();
      int a_cnt, p_e, r_e;
      a_cnt = 0; p_e = 0; r_e = 0;
      do_reset();
      raw_in = 4'b0010 ^ AL;
      for (int e = 1; e <= 25; e++) begin
         tick();
         if (action[1]) a_cnt++;
      end
      n_tests++;
      if (a_cnt !== 5) begin
         n_fail++;
         $display("FAIL pre_reset_actions got %0d want 5", a_cnt);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_tests++;
      if ({level, press, release_pulse, action} !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_mid_outputs got %b/%b/%b/%b want all 0", level, press, release_pulse, action);
      end
      for (int e = 1; e <= 25; e++) begin
         tick();
         if (press[1]) p_e = mn;
         if (action[1] && !press[1] && r_e == 0) r_e = mn;
         n_tests++;
         if ({level, press, release_pulse, action} !== {e_level, e_press, e_rel, e_action}) begin
            n_fail++;
            $display("FAIL reset_mid_model edge=%0d got %b/%b/%b/%b want %b/%b/%b/%b", mn,
                     level, press, release_pulse, action, e_level, e_press, e_rel, e_action);
         end
      end
      n_tests++;
      if (p_e !== 6 || r_e !== 16) begin
         n_fail++;
         $display("FAIL reset_redetect got press=%0d first_repeat=%0d want 6 and 16", p_e, r_e);
      end
   endtask

   task automatic test_multi();
      logic ep, ea;
      do_reset();
      raw_in = 4'b0011 ^ AL;
      for (int e = 1; e <= 40; e++) begin
         tick();
         ep = (mn == 6);
         ea = (mn == 6) || (mn >= 16 && (mn - 16) % 3 == 0);
         n_tests++;
         if (press[1:0] !== {2{ep}} || action[1:0] !== {2{ea}}) begin
            n_fail++;
            $display("FAIL multi_channel edge=%0d got p=%b a=%b want p=%b a=%b", mn,
                     press[1:0], action[1:0], {2{ep}}, {2{ea}});
         end
      end
   endtask

   task automatic test_random();
      logic [3:0] tgt, lg;
      int         noise [N];
      tgt = '0;
      for (int i = 0; i < N; i++) noise[i] = 0;
      do_reset();
      for (int cyc = 0; cyc < 800; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 39) == 0) begin
               tgt[i]   = ~tgt[i];
               noise[i] = $urandom_range(0, 6);
            end
         end
         lg = tgt;
         for (int i = 0; i < N; i++) begin
            if (noise[i] > 0) begin
               lg[i] = 1'($urandom_range(0, 1));
               noise[i]--;
            end
         end
         raw_in = lg ^ AL;
         if ($urandom_range(0, 149) == 0) enable = ~enable;
         reset = ($urandom_range(0, 399) == 0);
         tick();
         n_tests++;
         if ({level, press, release_pulse, action} !== {e_level, e_press, e_rel, e_action}) begin
            n_fail++;
            $display("FAIL random_model cyc=%0d edge=%0d got %b/%b/%b/%b want %b/%b/%b/%b", cyc, mn,
                     level, press, release_pulse, action, e_level, e_press, e_rel, e_action);
         end
      end
      reset  = 1'b0;
      enable = 1'b1;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_clean_hold();
      test_release();
      test_bounce();
      test_enable();
      test_reset_mid();
      test_multi();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
